// File: rtl/spi_slave_word.sv
// SPI slave that exchanges WIDTH-bit words with a master, fully oversampled in the clk domain.
// Optional frame-error pulse output is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_word #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             spi_clk,
    input  logic             mosi,
    input  logic [WIDTH-1:0] out_word,
    output logic             miso,
    output logic [WIDTH-1:0] in_word,
    output logic             finished,
    output logic             out_load,
    output logic             busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH);
    localparam logic             SCLK_IDLE = (CPOL != 0);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state, state_d;
    logic             cs_s1, cs_s2, cs_s3;
    logic             sclk_s1, sclk_s2, sclk_s3;
    logic             mosi_s1, mosi_s2;
    logic [2:0]       warm;
    logic             armed, armed_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [WIDTH-1:0] rx, rx_d;
    logic [WIDTH-1:0] tx, tx_d;
    logic [WIDTH-1:0] in_word_d;
    logic             miso_d, finished_d, out_load_d, busy_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic             frame_err_d;
`endif

    logic cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;
    logic lead_c, trail_c, sample_c, shift_c;

    assign cs_fall_c   = cs_s3 & ~cs_s2;
    assign cs_rise_c   = ~cs_s3 & cs_s2;
    assign sclk_rise_c = ~sclk_s3 & sclk_s2;
    assign sclk_fall_c = sclk_s3 & ~sclk_s2;
    assign lead_c      = SCLK_IDLE ? sclk_fall_c : sclk_rise_c;
    assign trail_c     = SCLK_IDLE ? sclk_rise_c : sclk_fall_c;
    assign sample_c    = (CPHA == 0) ? lead_c : trail_c;
    assign shift_c     = (CPHA == 0) ? trail_c : lead_c;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    // Next-state and datapath; a load with CPHA=0 presents bit 0 at once and pre-shifts tx
    always_comb begin
        state_d    = state;
        armed_d    = armed | (warm[2] & cs_s3);
        bit_cnt_d  = bit_cnt;
        rx_d       = rx;
        tx_d       = tx;
        in_word_d  = in_word;
        miso_d     = miso;
        finished_d = 1'b0;
        out_load_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                // armed blocks a cs that was already low across reset release
                if (armed && cs_fall_c) begin
                    state_d    = XFER;
                    rx_d       = '0;
                    tx_d       = out_word;
                    out_load_d = 1'b1;
                    if (CPHA == 0) begin
                        miso_d = first_bit(out_word);
                        tx_d   = shift_tx(out_word);
                    end
                end
            end
            XFER: begin
                if (cs_rise_c) begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err_d = (bit_cnt != '0);
`endif
                end else begin
                    if (finished) begin
                        tx_d       = out_word;
                        out_load_d = 1'b1;
                        if (CPHA == 0) begin
                            miso_d = first_bit(out_word);
                            tx_d   = shift_tx(out_word);
                        end
                    end else if (shift_c && ((CPHA != 0) || (bit_cnt != '0))) begin
                        // with CPHA=0 the shift edge closing a word is skipped; the reload owns miso
                        miso_d = first_bit(tx);
                        tx_d   = shift_tx(tx);
                    end
                    if (sample_c) begin
                        rx_d = shift_rx(rx, mosi_s2);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            in_word_d  = shift_rx(rx, mosi_s2);
                            finished_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == XFER);
    end

    // Synchronizers, state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_s3    <= 1'b1;
            sclk_s1  <= SCLK_IDLE;
            sclk_s2  <= SCLK_IDLE;
            sclk_s3  <= SCLK_IDLE;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            warm     <= '0;
            armed    <= 1'b0;
            state    <= IDLE;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            in_word  <= '0;
            miso     <= 1'b0;
            finished <= 1'b0;
            out_load <= 1'b0;
            busy     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            cs_s1    <= cs;
            cs_s2    <= cs_s1;
            cs_s3    <= cs_s2;
            sclk_s1  <= spi_clk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            mosi_s1  <= mosi;
            mosi_s2  <= mosi_s1;
            warm     <= {warm[1:0], 1'b1};
            armed    <= armed_d;
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            rx       <= rx_d;
            tx       <= tx_d;
            in_word  <= in_word_d;
            miso     <= miso_d;
            finished <= finished_d;
            out_load <= out_load_d;
            busy     <= busy_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= frame_err_d;
`endif
        end
    end

endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits (legal 4..32).
REQ-002 SHALL have parameter CPOL, default 0, meaning spi_clk idle level.
REQ-003 SHALL have parameter CPHA, default 0; 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 shifts MSB first, 0 shifts LSB first.
REQ-005 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cs  input  1  chip select, active low, asynchronous to clk.
REQ-008 SHALL have port spi_clk  input  1  SPI clock, asynchronous to clk.
REQ-009 SHALL have port mosi  input  1  serial data from master.
REQ-010 SHALL have port out_word  input  WIDTH  next word to transmit.
REQ-011 SHALL have port miso  output  1  serial data to master.
REQ-012 SHALL have port in_word  output  WIDTH  last complete received word.
REQ-013 SHALL have port finished  output  1  one-clk pulse marking a completed word.
REQ-014 SHALL have port out_load  output  1  one-clk pulse marking out_word captured.
REQ-015 SHALL have port busy  output  1  high while the synchronized cs is low.

Function
REQ-016 SHALL pass cs, spi_clk and mosi each through a 2-flop synchronizer before use; edges are detected against a third register.
REQ-017 SHALL require f_clk >= 8x f_spi_clk; behaviour below this ratio is undefined.
REQ-018 SHALL use states IDLE (cs high) and XFER (cs low); IDLE->XFER on synchronized cs fall, XFER->IDLE on synchronized cs rise.
REQ-019 SHALL define the leading edge as rising when CPOL=0 and falling when CPOL=1; the sample edge is leading if CPHA=0 and trailing if CPHA=1; the shift edge is the other edge.
REQ-020 SHALL capture out_word into the tx shift register and pulse out_load on IDLE->XFER, and again on the clk cycle after each finished.
REQ-021 SHALL present the first tx bit on miso within 1 clk after the load when CPHA=0; when CPHA=1, the first bit is presented on the first shift edge.
REQ-022 SHALL shift miso to the next bit on each shift edge, in MSB_FIRST order.
REQ-023 SHALL drive miso 0 in IDLE.
REQ-024 SHALL shift mosi into the rx register on each sample edge and count bits modulo WIDTH.
REQ-025 SHALL, on the WIDTH-th sample, update in_word and pulse finished for exactly one clk, no later than 4 clk rising edges after the pin edge.
REQ-026 SHALL hold in_word stable until the next finished.
REQ-027 SHALL support back-to-back words without cs release; the bit counter wraps to 0.
REQ-028 SHALL, when cs rises mid-word, discard the partial word, reset the bit counter, and neither pulse finished nor alter in_word.
REQ-029 SHALL ignore spi_clk edges while in IDLE.
REQ-030 SHALL give cs rise priority when it coincides with a sample edge: that sample is dropped.

Reset
REQ-031 SHALL, while rst is high, force: state IDLE; miso 0; in_word 0; finished 0; out_load 0; busy 0; bit counter 0; synchronizers to cs=1, spi_clk=CPOL, mosi=0.
REQ-032 SHALL, when rst asserts mid-transfer, abandon the partial word; after rst release, the next word starts only on a fresh cs fall.

Configuration
REQ-033 SHALL, with macro SPI_SLAVE_FRAME_ERR_EN defined, add output frame_err (1 bit, reset 0), which pulses one clk when cs rises with bit counter != 0.
REQ-034 SHALL, without SPI_SLAVE_FRAME_ERR_EN, have no frame_err port or logic; all other behaviour is unchanged.

Verification
REQ-035 SHALL cover: WIDTH=8, mode 0, master sends 0xA5 while out_word=0x59 -> in_word=0xA5, one finished pulse, master receives 0x59.
REQ-036 SHALL cover: WIDTH=16, CPOL=1, CPHA=1, two back-to-back words 0x1234, 0xBEEF under one cs -> two finished pulses in that order, out_load pulsed 2 times after the initial load.
REQ-037 SHALL cover: WIDTH=8, MSB_FIRST=0, master sends 0x01 LSB-first -> in_word=0x01; the first miso bit equals out_word[0].
REQ-038 SHALL cover: cs raised after 5 of 8 bits -> no finished, in_word retains 0xA5, frame_err pulses once when SPI_SLAVE_FRAME_ERR_EN is defined.
REQ-039 SHALL cover: rst pulsed after 3 bits, then a full 0x3C transfer -> in_word=0x3C; all outputs are 0 during rst.
